// File: rtl/alu_issue.sv
// RV32I OP/OP-IMM/LUI/AUIPC decode into ALU op + operands, queued in a 2-entry skid buffer.
// Latency 1 cycle; in_ready depends only on registered state, so a stalled ALU never has a combinational path back upstream. Optional macro: ALU_ISSUE_ILLEGAL_TRAP_EN.
module alu_issue #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 4,
    parameter int SHAMT_W     = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            instr,
    input  logic [DATA_WIDTH-1:0]  pc,
    input  logic [DATA_WIDTH-1:0]  rs1_val,
    input  logic [DATA_WIDTH-1:0]  rs2_val,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] operation,
    output logic [DATA_WIDTH-1:0]  op_a,
    output logic [DATA_WIDTH-1:0]  op_b,
    output logic [4:0]             rd_addr,
    output logic                   rd_we,
    output logic                   illegal
);

    localparam logic [INSTR_WIDTH-1:0] OP_ADD  = INSTR_WIDTH'(0);
    localparam logic [INSTR_WIDTH-1:0] OP_SLT  = INSTR_WIDTH'(1);
    localparam logic [INSTR_WIDTH-1:0] OP_SLTU = INSTR_WIDTH'(2);
    localparam logic [INSTR_WIDTH-1:0] OP_AND  = INSTR_WIDTH'(3);
    localparam logic [INSTR_WIDTH-1:0] OP_OR   = INSTR_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] OP_XOR  = INSTR_WIDTH'(5);
    localparam logic [INSTR_WIDTH-1:0] OP_SLL  = INSTR_WIDTH'(6);
    localparam logic [INSTR_WIDTH-1:0] OP_SRL  = INSTR_WIDTH'(7);
    localparam logic [INSTR_WIDTH-1:0] OP_SUB  = INSTR_WIDTH'(8);
    localparam logic [INSTR_WIDTH-1:0] OP_SRA  = INSTR_WIDTH'(9);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] op;
        logic [DATA_WIDTH-1:0]  a;
        logic [DATA_WIDTH-1:0]  b;
        logic [4:0]             rd;
        logic                   we;
    } entry_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       f7_zero;
    logic       f7_alt;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign f7_zero = (f7 == 7'h00);
    assign f7_alt  = (f7 == 7'h20);

    entry_t dec;
    logic   dec_illegal;

    always_comb begin
        dec         = '0;
        dec_illegal = 1'b0;
        dec.rd      = instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.a = rs1_val;
                dec.b = rs2_val;
                if (!(f7_zero || (f7_alt && (f3 == 3'd0 || f3 == 3'd5)))) begin
                    dec_illegal = 1'b1;
                end
                case (f3)
                    3'd0: dec.op = f7_alt ? OP_SUB : OP_ADD;
                    3'd1: dec.op = OP_SLL;
                    3'd2: dec.op = OP_SLT;
                    3'd3: dec.op = OP_SLTU;
                    3'd4: dec.op = OP_XOR;
                    3'd5: dec.op = f7_alt ? OP_SRA : OP_SRL;
                    3'd6: dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
                // Register shifts only ever see the low shift-amount bits.
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    dec.b = DATA_WIDTH'(rs2_val[SHAMT_W-1:0]);
                end
            end
            OPC_OP_IMM: begin
                dec.a = rs1_val;
                dec.b = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
                case (f3)
                    3'd0: dec.op = OP_ADD;
                    3'd1: begin
                        dec.op      = OP_SLL;
                        dec.b       = DATA_WIDTH'(instr[24:20]);
                        dec_illegal = !f7_zero;
                    end
                    3'd2: dec.op = OP_SLT;
                    3'd3: dec.op = OP_SLTU;
                    3'd4: dec.op = OP_XOR;
                    3'd5: begin
                        dec.op      = f7_alt ? OP_SRA : OP_SRL;
                        dec.b       = DATA_WIDTH'(instr[24:20]);
                        dec_illegal = !(f7_zero || f7_alt);
                    end
                    3'd6: dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
            end
            OPC_LUI: begin
                dec.op = OP_ADD;
                dec.b  = DATA_WIDTH'({instr[31:12], 12'b0});
            end
            OPC_AUIPC: begin
                dec.op = OP_ADD;
                dec.a  = pc;
                dec.b  = DATA_WIDTH'({instr[31:12], 12'b0});
            end
            default: dec_illegal = 1'b1;
        endcase
        dec.we = (dec.rd != 5'd0) && !dec_illegal;
        if (dec_illegal) begin
            dec.op = OP_ADD;
            dec.a  = '0;
            dec.b  = '0;
        end
    end

    logic [1:0] state_q, state_d;
    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic       accept;
    logic       xfer;
    logic       enq;

    assign in_ready  = (state_q != ST_TWO);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Trapped instructions consume the input slot but never reach the ALU.
    assign enq     = accept && !dec_illegal;
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= accept && dec_illegal;
        end
    end
`else
    assign enq     = accept;
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (enq) begin
                    head_d  = dec;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (enq && xfer) begin
                    head_d = dec;
                end else if (enq) begin
                    skid_d  = dec;
                    state_d = ST_TWO;
                end else if (xfer) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (xfer) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    assign operation = head_q.op;
    assign op_a      = head_q.a;
    assign op_b      = head_q.b;
    assign rd_addr   = head_q.rd;
    assign rd_we     = head_q.we;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: decode vector table plus skid-buffer stall, reset and illegal sequences.
module tb_alu_issue;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  operation;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic        illegal;

    alu_issue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc        (pc),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .operation (operation),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_addr   (rd_addr),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        enq;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[12];
    vec_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(input logic [31:0] i, input logic [31:0] p,
                                input logic [31:0] r1, input logic [31:0] r2,
                                input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic we, input logic enq);
        vec_t v;
        v.instr = i; v.pc = p; v.rs1 = r1; v.rs2 = r2;
        v.op = op; v.a = a; v.b = b; v.rd = rd; v.we = we; v.enq = enq;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every transfer the DUT commits to is popped and compared in order.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_issue: got op=%0d a=0x%0h, expected nothing", operation, op_a);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("op[%0h]", mon_e.instr), 32'(operation), 32'(mon_e.op));
                check($sformatf("a[%0h]", mon_e.instr), op_a, mon_e.a);
                check($sformatf("b[%0h]", mon_e.instr), op_b, mon_e.b);
                check($sformatf("rd[%0h]", mon_e.instr), 32'(rd_addr), 32'(mon_e.rd));
                check($sformatf("we[%0h]", mon_e.instr), 32'(rd_we), 32'(mon_e.we));
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input vec_t v);
        int n;
        n = 0;
        in_valid = 1'b1;
        instr    = v.instr;
        pc       = v.pc;
        rs1_val  = v.rs1;
        rs2_val  = v.rs2;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end else if (v.enq) begin
            exp_q.push_back(v);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vec_t bad;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; pc = '0; rs1_val = '0; rs2_val = '0;

        tbl[0]  = mk(32'h00500093, 0, 0, 0, 0, 0, 5, 1, 1, 1);
        tbl[1]  = mk(32'h402081B3, 0, 9, 4, 8, 9, 4, 3, 1, 1);
        tbl[2]  = mk(32'h002081B3, 0, 9, 4, 0, 9, 4, 3, 1, 1);
        tbl[3]  = mk(32'h40335293, 0, 32'h80000000, 0, 9, 32'h80000000, 3, 5, 1, 1);
        tbl[4]  = mk(32'h002091B3, 0, 7, 32'hFFFFFF21, 6, 7, 1, 3, 1, 1);
        tbl[5]  = mk(32'h123453B7, 0, 32'hDEAD, 0, 0, 0, 32'h12345000, 7, 1, 1);
        tbl[6]  = mk(32'h12345397, 32'h100, 0, 0, 0, 32'h100, 32'h12345000, 7, 1, 1);
        tbl[7]  = mk(32'hFFF08013, 0, 1, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 1);
        tbl[8]  = mk(32'h0070B113, 0, 1, 0, 2, 1, 7, 2, 1, 1);
        tbl[9]  = mk(32'h0020F233, 0, 32'hF0F0, 32'hFF00, 3, 32'hF0F0, 32'hFF00, 4, 1, 1);
        tbl[10] = mk(32'h0020D233, 0, 32'h80, 32'h25, 7, 32'h80, 5, 4, 1, 1);
        tbl[11] = mk(32'h8000C213, 0, 3, 0, 5, 3, 32'hFFFFF800, 4, 1, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_operation", 32'(operation), 0);
        check("rst_op_b", op_b, 0);
        check("rst_rd_we", 32'(rd_we), 0);
        check("rst_illegal", 32'(illegal), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: valid in the cycle right after the accepting edge.
        send(tbl[0]);
        check("latency_out_valid", 32'(out_valid), 1);
        for (int i = 1; i < 12; i++) begin
            send(tbl[i]);
        end
        drain();

        // Stall: two fill the buffer, third waits until the ALU side releases.
        out_ready = 1'b0;
        send(tbl[1]);
        check("one_in_ready", 32'(in_ready), 1);
        send(tbl[4]);
        check("two_in_ready", 32'(in_ready), 0);
        repeat (2) begin
            @(negedge clk);
            check("stall_op_a", op_a, exp_q[0].a);
            check("stall_op", 32'(operation), 32'(exp_q[0].op));
        end
        fork
            send(tbl[6]);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while full discards both entries.
        out_ready = 1'b0;
        send(tbl[2]);
        send(tbl[3]);
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_op_a", op_a, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 0);

        // SLLI with funct7=0x20 is illegal.
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        bad = mk(32'h40109093, 0, 5, 0, 0, 0, 0, 1, 0, 0);
        send(bad);
        check("trap_illegal_pulse", 32'(illegal), 1);
        check("trap_no_valid", 32'(out_valid), 0);
        @(posedge clk);
        #1;
        check("trap_illegal_clear", 32'(illegal), 0);
        check("trap_no_valid2", 32'(out_valid), 0);
`else
        bad = mk(32'h40109093, 0, 5, 0, 0, 0, 0, 1, 0, 1);
        send(bad);
        check("bubble_valid", 32'(out_valid), 1);
        check("bubble_illegal", 32'(illegal), 0);
        drain();
`endif
        send(tbl[8]);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
